// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for a 16-bit CPU memory stage.
// Requests are sampled only at accept; the response appears LATENCY edges later and holds until taken.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        count;
  logic [3:0]        count_next;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rdata_en;
  logic              err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_LIM);
  assign mem_idx   = req_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Storage carries no reset so it maps onto block RAM and survives rst.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      if (req_we) begin
        mem[mem_idx] <= req_wdata;
      end else begin
        rd_data <= mem[mem_idx];
      end
    end
  end

  // rdata_en masks the unreset RAM output register so stores, errors and reset read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_en <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      rdata_en <= in_range & ~req_we;
      err      <= ~in_range;
    end else if ((state == RESP) && rsp_ready) begin
      rdata_en <= 1'b0;
      err      <= 1'b0;
    end
  end

  assign rsp_rdata = rdata_en ? rd_data : '0;
  assign rsp_err   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three builds (default, DEPTH=200/LATENCY=1, LATENCY=15)
// checked against an array-based memory model and latency/handshake rules.
module tb_dmem_responder;

  localparam int N = 3;
  localparam int LAT [N] = '{2, 1, 15};
  localparam int DEP [N] = '{256, 200, 256};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_we    [N];
  logic [7:0]  req_addr  [N];
  logic [15:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [15:0] rsp_rdata [N];
  logic        rsp_err   [N];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [N][256];
  bit          known [N][256];
  time         acc_time;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      dmem_responder #(
        .ADDR_W (8),
        .DATA_W (16),
        .DEPTH  (DEP[gi]),
        .LATENCY(LAT[gi])
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid[gi]),
        .req_ready(req_ready[gi]),
        .req_we   (req_we[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi])
      );
    end
  endgenerate

  // Reference memory: what a response should carry, applying the store at accept.
  function automatic void ref_apply(input int k, input bit we, input logic [7:0] addr,
                                    input logic [15:0] wd, output logic [15:0] erd,
                                    output bit eerr, output bit edef);
    if (int'(addr) >= DEP[k]) begin
      erd = 16'h0; eerr = 1'b1; edef = 1'b1;
    end else if (we) begin
      model[k][addr] = wd;
      known[k][addr] = 1'b1;
      erd = 16'h0; eerr = 1'b0; edef = 1'b1;
    end else begin
      erd = model[k][addr]; eerr = 1'b0; edef = known[k][addr];
    end
  endfunction

  // Runs one request; reports observed data, latency in edges (-1 on timeout), hold stability and return to idle.
  task automatic txn(input int k, input bit we, input logic [7:0] addr, input logic [15:0] wd,
                     input int hold, input bit toggle, output logic [15:0] rd, output bit er,
                     output int lat, output bit stable, output bit idle_after);
    int guard;
    rd = 16'h0; er = 1'b0; lat = -1; stable = 1'b1; idle_after = 1'b0;
    guard = 0;
    while (req_ready[k] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready[k] !== 1'b1) return;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd;
    @(posedge clk);
    acc_time = $time;
    #1;
    req_valid[k] = 1'b0;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) break;
      if (req_ready[k] !== 1'b0) stable = 1'b0;
      if (lat >= 40) begin
        lat = -1;
        return;
      end
      if (toggle) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = 8'($urandom);
        req_wdata[k] = 16'($urandom);
        rsp_ready[k] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = (hold == 0);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    if (req_ready[k] !== 1'b0) stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd || rsp_err[k] !== er ||
          req_ready[k] !== 1'b0) stable = 1'b0;
      if (toggle) begin
        req_addr[k]  = 8'($urandom);
        req_wdata[k] = 16'($urandom);
      end
      rsp_ready[k] = (i == hold - 1);
    end
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    idle_after = (rsp_valid[k] === 1'b0) && (req_ready[k] === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 16'h0 || rsp_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got valid=%b rdata=%h err=%b required 0/0000/0",
                 k, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b required 1", k, req_ready[k]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [15:0] rd, erd;
    bit er, eerr, edef, st, idl;
    int lat;
    bit we_t [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      ref_apply(0, we_t[i], 8'h10, 16'hBEEF, erd, eerr, edef);
      txn(0, we_t[i], 8'h10, 16'hBEEF, 0, 1'b0, rd, er, lat, st, idl);
      checks++;
      if (rd !== erd || er !== eerr) begin
        errors++;
        $display("FAIL store_load[%0d]: got rdata=%h err=%b required %h/%b", i, rd, er, erd, eerr);
      end
      checks++;
      if (lat !== 2 || !idl) begin
        errors++;
        $display("FAIL store_load_lat[%0d]: got lat=%0d idle=%b required 2/1", i, lat, idl);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] rd, erd;
    bit er, eerr, edef, st, idl;
    int lat;
    ref_apply(0, 1'b0, 8'h10, 16'h0, erd, eerr, edef);
    txn(0, 1'b0, 8'h10, 16'h0, 5, 1'b0, rd, er, lat, st, idl);
    checks++;
    if (rd !== erd || er !== eerr) begin
      errors++;
      $display("FAIL hold_data: got rdata=%h err=%b required %h/%b", rd, er, erd, eerr);
    end
    checks++;
    if (!st || !idl || lat !== 2) begin
      errors++;
      $display("FAIL hold_stable: got stable=%b idle=%b lat=%0d required 1/1/2", st, idl, lat);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd, erd;
    bit er, eerr, edef, st, idl;
    int lat;
    bit          ow [9] = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
    logic [7:0]  oa [9] = '{8'hC7, 8'h00, 8'h37, 8'hC8, 8'hFF, 8'hC7, 8'h00, 8'h37, 8'hC8};
    logic [15:0] od [9] = '{16'h7E7E, 16'h0101, 16'h5555, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 9; i++) begin
      ref_apply(1, ow[i], oa[i], od[i], erd, eerr, edef);
      txn(1, ow[i], oa[i], od[i], 0, 1'b0, rd, er, lat, st, idl);
      checks++;
      if (rd !== erd || er !== eerr || lat !== 1) begin
        errors++;
        $display("FAIL range[%0d] addr=%h: got rdata=%h err=%b lat=%0d required %h/%b/1",
                 i, oa[i], rd, er, lat, erd, eerr);
      end
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [15:0] rd, erd;
    bit er, eerr, edef, st, idl;
    int lat;
    time prev;
    for (int i = 0; i < 4; i++) begin
      ref_apply(k, 1'b1, 8'(8'h40 + i), 16'(16'h3000 + i * 7), erd, eerr, edef);
      txn(k, 1'b1, 8'(8'h40 + i), 16'(16'h3000 + i * 7), 0, 1'b0, rd, er, lat, st, idl);
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      ref_apply(k, 1'b0, 8'(8'h40 + i), 16'h0, erd, eerr, edef);
      txn(k, 1'b0, 8'(8'h40 + i), 16'h0, 0, 1'b0, rd, er, lat, st, idl);
      checks++;
      if (rd !== erd || lat !== LAT[k]) begin
        errors++;
        $display("FAIL b2b[%0d.%0d]: got rdata=%h lat=%0d required %h/%0d", k, i, rd, lat, erd, LAT[k]);
      end
      if (i > 0) begin
        checks++;
        if ((acc_time - prev) != time'((LAT[k] + 1) * 10)) begin
          errors++;
          $display("FAIL b2b_spacing[%0d.%0d]: got %0t required %0d", k, i, acc_time - prev,
                   (LAT[k] + 1) * 10);
        end
      end
      prev = acc_time;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] rd, erd;
    bit er, eerr, edef, st, idl, seen;
    int lat;
    ref_apply(0, 1'b1, 8'h03, 16'h1111, erd, eerr, edef);
    txn(0, 1'b1, 8'h03, 16'h1111, 0, 1'b0, rd, er, lat, st, idl);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h03; req_wdata[0] = 16'hA5A5;
    @(posedge clk);
    ref_apply(0, 1'b1, 8'h03, 16'hA5A5, erd, eerr, edef);
    #1;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) seen = 1'b1;
      if (i == 1) rst = 1'b0;
    end
    rsp_ready[0] = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_in_wait_drop: got rsp_valid=1 required 0");
    end
    ref_apply(0, 1'b0, 8'h03, 16'h0, erd, eerr, edef);
    txn(0, 1'b0, 8'h03, 16'h0, 0, 1'b0, rd, er, lat, st, idl);
    checks++;
    if (rd !== erd || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL rst_in_wait_commit: got rdata=%h err=%b lat=%0d required %h/0/2", rd, er, lat, erd);
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [15:0] rd, erd, wd;
    logic [7:0] addr;
    bit er, eerr, edef, st, idl, we, tg;
    int lat, hold;
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      wd   = 16'($urandom);
      hold = $urandom_range(0, 3);
      tg   = 1'($urandom_range(0, 1));
      ref_apply(k, we, addr, wd, erd, eerr, edef);
      txn(k, we, addr, wd, hold, tg, rd, er, lat, st, idl);
      checks++;
      if ((edef && rd !== erd) || er !== eerr) begin
        errors++;
        $display("FAIL rand[%0d.%0d] we=%b addr=%h: got rdata=%h err=%b required %h/%b",
                 k, i, we, addr, rd, er, erd, eerr);
      end
      checks++;
      if (lat !== LAT[k] || !st || !idl) begin
        errors++;
        $display("FAIL rand_proto[%0d.%0d]: got lat=%0d stable=%b idle=%b required %0d/1/1",
                 k, i, lat, st, idl, LAT[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 8'h0;
      req_wdata[k] = 16'h0; rsp_ready[k] = 1'b0;
      for (int a = 0; a < 256; a++) known[k][a] = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_hold();
    test_out_of_range();
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_in_wait();
    test_random(0, 40);
    test_random(1, 20);
    test_random(2, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
